// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle MIPS sequencing controller.
// Optional retired-instruction counter is enabled by MULTICYCLE_INSTRET_EN.
package multicycle_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned INSTRET_W = 32;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_IMMEX,
        S_IMMWB,
        S_JUMP,
        S_ILLEGAL
    } state_t;

    // ALU operation class handed to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT,
        ALUOP_SLT
    } aluop_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] F_ADD = 6'b100000;
    localparam logic [OP_W-1:0] F_SUB = 6'b100010;
    localparam logic [OP_W-1:0] F_AND = 6'b100100;
    localparam logic [OP_W-1:0] F_OR  = 6'b100101;
    localparam logic [OP_W-1:0] F_SLT = 6'b101010;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALURES = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the operation class and R-type funct to an ALU control code.
module mc_aludec
    import multicycle_pkg::*;
(
    input  aluop_t          aluop,
    input  logic [OP_W-1:0] funct,
    output logic [2:0]      alucontrol,
    output logic            funct_valid
);

    always_comb begin
        alucontrol  = ALU_ADD;
        funct_valid = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_SLT: alucontrol = ALU_SLT;
            ALUOP_FUNCT: begin
                funct_valid = 1'b1;
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: funct_valid = 1'b0;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencing controller: Moore FSM with memready wait states.
// Define MULTICYCLE_INSTRET_EN to build the retired-instruction counter.
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [OP_W-1:0]      funct,
    input  logic                 zero,
    input  logic                 memready,
    output logic                 iord,
    output logic                 irwrite,
    output logic                 memwrite,
    output logic                 memtoreg,
    output logic                 regdst,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [2:0]           alucontrol,
    output logic [1:0]           pcsrc,
    output logic                 pcen,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    state_t state;
    aluop_t aluop;
    logic   funct_valid;
    logic   pcwrite;
    logic   taken;

    // bne is the odd opcode, so op[0] inverts the zero test
    assign taken = zero ^ op[0];

    mc_aludec u_aludec (
        .aluop       (aluop),
        .funct       (funct),
        .alucontrol  (alucontrol),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  if (memready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW:     state <= S_MEMADR;
                        OP_RTYPE:         state <= S_EXEC;
                        OP_BEQ, OP_BNE:   state <= S_BRANCH;
                        OP_ADDI, OP_SLTI: state <= S_IMMEX;
                        OP_J:             state <= S_JUMP;
                        default:          state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR: state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (memready) state <= S_MEMWB;
                S_MEMWR:  if (memready) state <= S_FETCH;
                S_EXEC:   state <= funct_valid ? S_ALUWB : S_ILLEGAL;
                S_IMMEX:  state <= S_IMMWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: state <= S_FETCH;
                S_ILLEGAL: state <= S_ILLEGAL;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Output decode from the registered state; FETCH enables follow memready
    always_comb begin
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_REG;
        pcsrc    = PC_ALURES;
        pcwrite  = 1'b0;
        illegal  = 1'b0;
        aluop    = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                irwrite = memready;
                pcwrite = memready;
            end
            S_DECODE: alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PC_ALUOUT;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = (op == OP_SLTI) ? ALUOP_SLT : ALUOP_ADD;
            end
            S_IMMWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
    end

    assign pcen = pcwrite | ((state == S_BRANCH) & taken);

`ifdef MULTICYCLE_INSTRET_EN
    logic retire;

    assign retire = (state == S_MEMWB) | (state == S_ALUWB) | (state == S_BRANCH) |
                    (state == S_IMMWB) | (state == S_JUMP) |
                    ((state == S_MEMWR) & memready);

    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + INSTRET_W'(1);
        end
    end
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expected cycle sequences
// are built from the instruction rules and compared by an independent monitor.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset, zero, memready;
    logic [5:0]  op, funct;
    logic        iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic        pcen, illegal;
    logic [31:0] instret;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memready(memready), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
        .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic [1:0] pcsrc;
        logic       pcen, illegal;
    } exp_t;

    typedef struct { exp_t v; logic [31:0] ret; string tag; } sb_t;
    typedef struct { logic mr; logic rst; logic retire; exp_t v; } cyc_t;

    sb_t         sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_ret = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ret_exp(input logic [31:0] r);
`ifdef MULTICYCLE_INSTRET_EN
        return r;
`else
        return 32'd0 & r;
`endif
    endfunction

    // Monitor: compares every presented cycle against the scoreboard head
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t  s;
            exp_t act;
            s   = sb.pop_front();
            act = {iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca,
                   alusrcb, alucontrol, pcsrc, pcen, illegal};
            check({s.tag, ".out"}, 32'(act), 32'(s.v));
            check({s.tag, ".instret"}, instret, s.ret);
        end
    end

    function automatic cyc_t mk(input logic mr);
        cyc_t c;
        c.mr = mr; c.rst = 1'b0; c.retire = 1'b0;
        c.v = '0; c.v.alucontrol = 3'b010;
        return c;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f, output logic ok);
        ok = 1'b1;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default: begin ok = 1'b0; return 3'b010; end
        endcase
    endfunction

    task automatic illegal_tail(inout cyc_t q[$]);
        cyc_t c;
        for (int k = 0; k < 3; k++) begin
            c = mk(rnd());
            c.v.illegal = 1'b1;
            c.rst = (k == 2);
            q.push_back(c);
        end
    endtask

    // Expand one instruction into its expected cycles, then drive and score them
    task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                             input int fw, input int mw, input logic z, input bit abort);
        cyc_t q[$];
        cyc_t c;
        logic ok;
        op = o; funct = f; zero = z;
        for (int k = 0; k < fw; k++) begin
            c = mk(1'b0); c.v.alusrcb = 2'b01; q.push_back(c);
        end
        c = mk(1'b1); c.v.alusrcb = 2'b01; c.v.irwrite = 1'b1; c.v.pcen = 1'b1; q.push_back(c);
        c = mk(rnd()); c.v.alusrcb = 2'b11; q.push_back(c);
        case (o)
            6'b100011, 6'b101011: begin
                c = mk(rnd()); c.v.alusrca = 1'b1; c.v.alusrcb = 2'b10; q.push_back(c);
                for (int k = 0; k < mw; k++) begin
                    c = mk(1'b0); c.v.iord = 1'b1; c.v.memwrite = (o == 6'b101011);
                    c.rst = abort && (k == mw - 1);
                    q.push_back(c);
                end
                if (!abort) begin
                    c = mk(1'b1); c.v.iord = 1'b1;
                    if (o == 6'b101011) begin
                        c.v.memwrite = 1'b1; c.retire = 1'b1; q.push_back(c);
                    end else begin
                        q.push_back(c);
                        c = mk(rnd()); c.v.memtoreg = 1'b1; c.v.regwrite = 1'b1;
                        c.retire = 1'b1; q.push_back(c);
                    end
                end
            end
            6'b000000: begin
                c = mk(rnd()); c.v.alusrca = 1'b1; c.v.alucontrol = rtype_alu(f, ok);
                q.push_back(c);
                if (ok) begin
                    c = mk(rnd()); c.v.regdst = 1'b1; c.v.regwrite = 1'b1;
                    c.retire = 1'b1; q.push_back(c);
                end else begin
                    illegal_tail(q);
                end
            end
            6'b000100, 6'b000101: begin
                c = mk(rnd()); c.v.alusrca = 1'b1; c.v.alucontrol = 3'b110; c.v.pcsrc = 2'b01;
                c.v.pcen = (o == 6'b000100) ? z : !z;
                c.retire = 1'b1; q.push_back(c);
            end
            6'b001000, 6'b001010: begin
                c = mk(rnd()); c.v.alusrca = 1'b1; c.v.alusrcb = 2'b10;
                c.v.alucontrol = (o == 6'b001010) ? 3'b111 : 3'b010; q.push_back(c);
                c = mk(rnd()); c.v.regwrite = 1'b1; c.retire = 1'b1; q.push_back(c);
            end
            6'b000010: begin
                c = mk(rnd()); c.v.pcsrc = 2'b10; c.v.pcen = 1'b1; c.retire = 1'b1;
                q.push_back(c);
            end
            default: illegal_tail(q);
        endcase
        foreach (q[i]) begin
            sb_t s;
            memready = q[i].mr;
            reset    = q[i].rst;
            s.v = q[i].v; s.ret = ret_exp(model_ret); s.tag = $sformatf("%s.c%0d", name, i + 1);
            sb.push_back(s);
            @(posedge clk); #1;
            if (q[i].rst) begin
                reset = 1'b0;
                model_ret = '0;
            end else if (q[i].retire) begin
                model_ret = model_ret + 32'd1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] ops [10];
    logic [5:0] fns [5];

    initial begin
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
                6'b000101, 6'b001000, 6'b001010, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        reset = 1'b1; memready = 1'b0; op = '0; funct = '0; zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; model_ret = '0;
        check("reset.illegal", 32'(illegal), 32'd0);
        check("reset.instret", instret, 32'd0);

        run_instr("lw_wait", 6'b100011, 6'h00, 2, 2, 1'b0, 1'b0);
        run_instr("sw",      6'b101011, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr("beq_z1",  6'b000100, 6'h00, 0, 0, 1'b1, 1'b0);
        run_instr("bne_z1",  6'b000101, 6'h00, 0, 0, 1'b1, 1'b0);
        run_instr("beq_z0",  6'b000100, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr("bne_z0",  6'b000101, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr("or",      6'b000000, 6'b100101, 0, 0, 1'b0, 1'b0);
        run_instr("badfn",   6'b000000, 6'b000000, 0, 0, 1'b0, 1'b0);
        run_instr("lw_abort", 6'b100011, 6'h00, 0, 1, 1'b0, 1'b1);
        run_instr("addi",    6'b001000, 6'h00, 1, 0, 1'b0, 1'b0);
        run_instr("j",       6'b000010, 6'h00, 0, 0, 1'b0, 1'b0);
        run_instr("beq",     6'b000100, 6'h00, 0, 0, 1'b1, 1'b0);
`ifdef MULTICYCLE_INSTRET_EN
        check("instret_three", instret, 32'd3);
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        model_ret = 32'hFFFF_FFFF;
        run_instr("wrap", 6'b001010, 6'h00, 0, 0, 1'b0, 1'b0);
        check("instret_wrap", instret, 32'd0);
`else
        check("instret_tied", instret, 32'd0);
`endif

        for (int n = 0; n < 60; n++) begin
            int   idx;
            logic [5:0] f;
            idx = (($urandom_range(0, 19)) == 19) ? 9 : int'($urandom_range(0, 8));
            f = ($urandom_range(0, 9) == 0) ? 6'b111111 : fns[$urandom_range(0, 4)];
            run_instr($sformatf("rnd%0d", n), ops[idx], f, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), rnd(), 1'b0);
        end

        @(posedge clk); #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
